// File: rtl/mips_pkg.sv
// Shared constants for the pipeline's memory port arbiter: FSM encoding,
// port identifiers and the full-word byte-enable pattern.
package mips_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE   = 2'd0;
   localparam arb_state_t ARB_I_BUSY = 2'd1;
   localparam arb_state_t ARB_D_BUSY = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating 4-bit count of data grants made while fetch was waiting;
// at_limit_o tells the arbiter to hand the next contested slot to fetch.
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] count_q;
   logic [3:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 4'd0;
      end else if (inc_i && (count_q < LIMIT)) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (read-only) and data
// (read/write) ports; data wins contested slots until fetch has starved.
module mem_port_arbiter
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_IReq,
   input  logic [ADDRESS_WIDTH-1:0] i_IAddr,
   output logic [DATA_WIDTH-1:0]    o_IRdata,
   output logic                     o_IValid,
   output logic                     o_StallIF,
   input  logic                     i_DReq,
   input  logic                     i_DWe,
   input  logic [ADDRESS_WIDTH-1:0] i_DAddr,
   input  logic [DATA_WIDTH-1:0]    i_DWdata,
   input  logic [3:0]               i_DBe,
   output logic [DATA_WIDTH-1:0]    o_DRdata,
   output logic                     o_DValid,
   output logic                     o_StallMEM,
   output logic                     o_MemReq,
   output logic                     o_MemWe,
   output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
   output logic [DATA_WIDTH-1:0]    o_MemWdata,
   output logic [3:0]               o_MemBe,
   input  logic [DATA_WIDTH-1:0]    i_MemRdata,
   input  logic                     i_MemAck
);

   arb_state_t state_q;
   arb_state_t state_d;

   logic i_elig;
   logic d_elig;
   logic at_limit;
   logic grant_i;
   logic grant_d;
   logic done_i;
   logic done_d;

   logic                     mem_req_q;
   logic                     mem_we_q;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0]    mem_wdata_q;
   logic [3:0]               mem_be_q;
   logic                     ivalid_q;
   logic                     dvalid_q;
   logic [DATA_WIDTH-1:0]    irdata_q;
   logic [DATA_WIDTH-1:0]    drdata_q;

   // A port in its own completion cycle is not eligible, so the other port
   // is granted in that cycle instead of the same port being re-granted.
   assign i_elig = i_IReq & ~ivalid_q;
   assign d_elig = i_DReq & ~dvalid_q;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               state_d = ARB_D_BUSY;
            end else if (grant_i) begin
               state_d = ARB_I_BUSY;
            end
         end
         ARB_I_BUSY, ARB_D_BUSY: begin
            if (i_MemAck) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      done_i  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            grant_d = d_elig & (~i_elig | ~at_limit);
            grant_i = i_elig & ~grant_d;
         end
         ARB_I_BUSY: done_i = i_MemAck;
         ARB_D_BUSY: done_d = i_MemAck;
         default: ;
      endcase
   end

   arb_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i      (i_CLK),
      .rst_i      (i_RST),
      .inc_i      (grant_d & i_elig),
      .clr_i      (grant_i),
      .at_limit_o (at_limit)
   );

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'h0;
         ivalid_q    <= 1'b0;
         dvalid_q    <= 1'b0;
         irdata_q    <= '0;
         drdata_q    <= '0;
      end else begin
         if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_DWe;
            mem_addr_q  <= i_DAddr;
            mem_wdata_q <= i_DWdata;
            mem_be_q    <= i_DBe;
         end else if (grant_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_IAddr;
            mem_wdata_q <= '0;
            mem_be_q    <= BE_WORD;
         end else if (done_i | done_d) begin
            mem_req_q   <= 1'b0;
         end
         ivalid_q <= done_i;
         dvalid_q <= done_d;
         if (done_i) begin
            irdata_q <= i_MemRdata;
         end
         if (done_d && !mem_we_q) begin
            drdata_q <= i_MemRdata;
         end
      end
   end

   assign o_MemReq   = mem_req_q;
   assign o_MemWe    = mem_we_q;
   assign o_MemAddr  = mem_addr_q;
   assign o_MemWdata = mem_wdata_q;
   assign o_MemBe    = mem_be_q;
   assign o_IValid   = ivalid_q;
   assign o_DValid   = dvalid_q;
   assign o_IRdata   = irdata_q;
   assign o_DRdata   = drdata_q;
   assign o_StallIF  = i_IReq & ~ivalid_q;
   assign o_StallMEM = i_DReq & ~dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed corner cases followed by
// randomized concurrent fetch/data traffic against a variable-latency memory.
module tb_mem_port_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_IReq;
   logic [AW-1:0] i_IAddr;
   logic [DW-1:0] o_IRdata;
   logic          o_IValid;
   logic          o_StallIF;
   logic          i_DReq;
   logic          i_DWe;
   logic [AW-1:0] i_DAddr;
   logic [DW-1:0] i_DWdata;
   logic [3:0]    i_DBe;
   logic [DW-1:0] o_DRdata;
   logic          o_DValid;
   logic          o_StallMEM;
   logic          o_MemReq;
   logic          o_MemWe;
   logic [AW-1:0] o_MemAddr;
   logic [DW-1:0] o_MemWdata;
   logic [3:0]    o_MemBe;
   logic [DW-1:0] i_MemRdata;
   logic          i_MemAck;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .STARVE_LIMIT  (LIM)
   ) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_IReq     (i_IReq),
      .i_IAddr    (i_IAddr),
      .o_IRdata   (o_IRdata),
      .o_IValid   (o_IValid),
      .o_StallIF  (o_StallIF),
      .i_DReq     (i_DReq),
      .i_DWe      (i_DWe),
      .i_DAddr    (i_DAddr),
      .i_DWdata   (i_DWdata),
      .i_DBe      (i_DBe),
      .o_DRdata   (o_DRdata),
      .o_DValid   (o_DValid),
      .o_StallMEM (o_StallMEM),
      .o_MemReq   (o_MemReq),
      .o_MemWe    (o_MemWe),
      .o_MemAddr  (o_MemAddr),
      .o_MemWdata (o_MemWdata),
      .o_MemBe    (o_MemBe),
      .i_MemRdata (i_MemRdata),
      .i_MemAck   (i_MemAck)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Contents of any memory word never written.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a & ~32'h3) ^ 32'h2002_0045;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // ---------------- memory responder ----------------
   logic [31:0] mem_store [logic [31:0]];
   int  wait_mode    = 0;
   bit  spurious_req = 0;

   initial begin
      bit          active;
      int          wait_left;
      logic [31:0] wa;
      logic [31:0] cur;
      active    = 0;
      wait_left = 0;
      i_MemAck   = 1'b0;
      i_MemRdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!o_MemReq) begin
            active   = 0;
            i_MemAck = spurious_req;
            if (spurious_req) i_MemRdata = $urandom;
         end else begin
            if (!active) begin
               active    = 1;
               wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            end
            if (wait_left == 0) begin
               i_MemAck = 1'b1;
               wa  = o_MemAddr & ~32'h3;
               cur = mem_store.exists(wa) ? mem_store[wa] : init_word(wa);
               if (o_MemWe) begin
                  mem_store[wa] = merge(cur, o_MemWdata, o_MemBe);
                  i_MemRdata    = $urandom;
               end else begin
                  i_MemRdata = cur;
               end
            end else begin
               i_MemAck = 1'b0;
               wait_left--;
            end
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      bit          we;
      logic [31:0] data;
   } dexp_t;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] exp_i [$];
   dexp_t       exp_d [$];

   task automatic issue_i(input logic [31:0] a);
      i_IReq  = 1'b1;
      i_IAddr = a;
      exp_i.push_back(init_word(a));
   endtask

   task automatic issue_d(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
      logic [31:0] wa;
      logic [31:0] cur;
      dexp_t       e;
      wa  = a & ~32'h3;
      cur = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
      i_DReq   = 1'b1;
      i_DWe    = we;
      i_DAddr  = a;
      i_DWdata = wd;
      i_DBe    = be;
      e.we = we;
      if (we) begin
         ref_mem[wa] = merge(cur, wd, be);
         e.data      = '0;
      end else begin
         e.data = cur;
      end
      exp_d.push_back(e);
   endtask

   initial begin
      logic [31:0] last_dr;
      logic [31:0] v;
      dexp_t       e;
      last_dr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_dr = '0;
         end else begin
            if (o_IValid) begin
               if (exp_i.size() == 0) fail_now("i_unexpected_valid");
               else begin
                  v = exp_i.pop_front();
                  chk("i_rdata", o_IRdata, v);
               end
            end
            if (o_DValid) begin
               if (exp_d.size() == 0) fail_now("d_unexpected_valid");
               else begin
                  e = exp_d.pop_front();
                  if (e.we) chk("d_write_keeps_rdata", o_DRdata, last_dr);
                  else begin
                     chk("d_rdata", o_DRdata, e.data);
                     last_dr = e.data;
                  end
               end
            end
         end
      end
   end

   // ---------------- bus / arbitration checker ----------------
   initial begin
      bit          have_prev, prev_req, prev_ack, prev_el_i, el_i, el_d;
      int          exp_grant, held_port, tally;
      logic [31:0] exp_addr, exp_wdata, held_addr, held_wdata;
      logic [4:0]  exp_ctl, held_ctl;
      have_prev = 0; prev_req = 0; prev_ack = 0; prev_el_i = 0;
      exp_grant = 0; held_port = 0; tally = 0;
      exp_addr = '0; exp_wdata = '0; exp_ctl = '0;
      held_addr = '0; held_wdata = '0; held_ctl = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            have_prev = 0;
            tally     = 0;
            held_port = 0;
         end else begin
            chk("stall_if",  o_StallIF,  i_IReq & ~o_IValid);
            chk("stall_mem", o_StallMEM, i_DReq & ~o_DValid);
            if (have_prev) begin
               chk("i_valid_pulse", o_IValid, prev_req && prev_ack && held_port == 1);
               chk("d_valid_pulse", o_DValid, prev_req && prev_ack && held_port == 2);
               if (prev_req) begin
                  if (prev_ack) chk("req_drop_on_ack", o_MemReq, 0);
                  else begin
                     chk("req_hold", o_MemReq, 1);
                     chk("hold_addr", o_MemAddr, held_addr);
                     chk("hold_wdata", o_MemWdata, held_wdata);
                     chk("hold_ctl", {o_MemWe, o_MemBe}, held_ctl);
                  end
               end else if (exp_grant == 0) begin
                  chk("idle_no_req", o_MemReq, 0);
               end else begin
                  chk("grant_req", o_MemReq, 1);
                  chk(exp_grant == 2 ? "grant_d_addr" : "grant_i_addr", o_MemAddr, exp_addr);
                  chk("grant_ctl", {o_MemWe, o_MemBe}, exp_ctl);
                  if (exp_grant == 2) chk("grant_wdata", o_MemWdata, exp_wdata);
                  held_addr  = o_MemAddr;
                  held_wdata = o_MemWdata;
                  held_ctl   = {o_MemWe, o_MemBe};
                  held_port  = exp_grant;
                  if (exp_grant == 1) tally = 0;
                  else if (prev_el_i && tally < LIM) tally++;
               end
            end
            have_prev = 1;
            prev_req  = o_MemReq;
            prev_ack  = i_MemAck;
            el_i      = i_IReq && !o_IValid;
            el_d      = i_DReq && !o_DValid;
            prev_el_i = el_i;
            exp_grant = 0;
            if (!o_MemReq) begin
               if (el_d && (!el_i || tally < LIM)) begin
                  exp_grant = 2;
                  exp_addr  = i_DAddr;
                  exp_wdata = i_DWdata;
                  exp_ctl   = {i_DWe, i_DBe};
               end else if (el_i) begin
                  exp_grant = 1;
                  exp_addr  = i_IAddr;
                  exp_ctl   = {1'b0, 4'hF};
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_i();
      int t = 0;
      do begin tick(); t++; end while (!o_IValid && t < 200);
      if (!o_IValid) fail_now("i_timeout");
      i_IReq = 1'b0;
   endtask

   task automatic wait_d();
      int t = 0;
      do begin tick(); t++; end while (!o_DValid && t < 200);
      if (!o_DValid) fail_now("d_timeout");
      i_DReq = 1'b0;
   endtask

   task automatic fetch_stream(input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         issue_i({20'h0, 10'($urandom_range(0, 1023)), 2'b00});
         wait_i();
      end
   endtask

   task automatic data_stream(input int n);
      logic [3:0] be_tab [7];
      bit         we;
      be_tab = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         we = 1'($urandom_range(0, 1));
         issue_d(we, 32'h1000_0000 + 32'(4 * $urandom_range(0, 15)), $urandom,
                 we ? be_tab[$urandom_range(0, 6)] : 4'hF);
         wait_d();
      end
   endtask

   initial begin
      int t, d_t, i_t, hi, pulses;
      rst = 1'b1;
      i_IReq = 0; i_IAddr = '0; i_DReq = 0; i_DWe = 0;
      i_DAddr = '0; i_DWdata = '0; i_DBe = '0;

      // Reset with fetch request held, then zero-wait fetch
      i_IReq  = 1'b1;
      i_IAddr = 32'h0000_0040;
      repeat (3) @(negedge clk);
      chk("rst_flags", {o_MemReq, o_MemWe, o_IValid, o_DValid}, 4'h0);
      chk("rst_mem_addr", o_MemAddr, 0);
      chk("rst_mem_wdata", o_MemWdata, 0);
      chk("rst_mem_be", o_MemBe, 0);
      chk("rst_irdata", o_IRdata, 0);
      chk("rst_drdata", o_DRdata, 0);
      tick();
      rst = 1'b0;
      exp_i.push_back(init_word(32'h0000_0040));
      t = 0;
      do begin @(negedge clk); t++; end while (!o_IValid && t < 10);
      chk("i_first_latency", t, 3);
      tick();
      i_IReq = 1'b0;

      // Simultaneous requests: data first, then fetch
      issue_i(32'h0000_0080);
      issue_d(0, 32'h1000_0000, '0, 4'hF);
      d_t = -1; i_t = -1; t = 0;
      while ((d_t < 0 || i_t < 0) && t < 50) begin
         tick(); t++;
         if (o_DValid) begin i_DReq = 0; d_t = t; end
         if (o_IValid) begin i_IReq = 0; i_t = t; end
      end
      chk("data_before_fetch", (d_t > 0) && (i_t > d_t), 1);

      // Partial write with three wait states
      wait_mode = 3;
      tick();
      issue_d(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
      hi = 0; pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         hi += int'(o_MemReq);
         pulses += int'(o_DValid);
         tick();
         if (o_DValid) i_DReq = 0;
      end
      chk("wr_busy_cycles", hi, 4);
      chk("wr_valid_pulses", pulses, 1);
      wait_mode = 0;
      issue_d(0, 32'h1000_0004, '0, 4'hF);
      wait_d();

      // Asynchronous reset in D_BUSY
      wait_mode = 6;
      tick();
      issue_d(0, 32'h1000_0008, '0, 4'hF);
      t = 0;
      do begin @(negedge clk); t++; end while (!o_MemReq && t < 10);
      #2;
      rst    = 1'b1;
      i_DReq = 1'b0;
      #1;
      chk("async_rst_req_drop", o_MemReq, 0);
      void'(exp_d.pop_back());
      tick(); tick();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         pulses += int'(o_DValid) + int'(o_MemReq);
      end
      chk("no_activity_after_rst", pulses, 0);
      wait_mode = 0;
      tick();
      issue_d(0, 32'h1000_0008, '0, 4'hF);
      wait_d();

      // Spurious ack in IDLE
      @(negedge clk);
      spurious_req = 1;
      @(negedge clk);
      spurious_req = 0;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         pulses += int'(o_IValid) + int'(o_DValid) + int'(o_MemReq);
      end
      chk("spurious_ack_ignored", pulses, 0);

      // Randomized concurrent traffic
      wait_mode = -1;
      tick();
      fork
         fetch_stream(60);
         data_stream(60);
      join
      repeat (5) tick();
      chk("i_queue_drained", exp_i.size(), 0);
      chk("d_queue_drained", exp_d.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
